// File: rtl/fetch_unit_pkg.sv
// Shared core-wide definitions for the instruction-fetch stage.
package fetch_unit_pkg;

  // Fetch FSM encodings.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem req/gnt/rvalid, decode valid/ready, redirect/halt, status.
interface fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            halt_req;
  logic            halted;
  logic            misaligned;
  logic [31:0]     retire_count;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
           halted, misaligned, retire_count,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready,
           redirect, redirect_target, halt_req
  );

  // Memory / decode / execute side.
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
           halted, misaligned, retire_count,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready,
           redirect, redirect_target, halt_req
  );
endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter register with synchronous reset and load enable.
module pc_register #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);

  // Reset dominates; otherwise take next_pc only when loaded.
  always_ff @(posedge clk) begin
    if (reset)     pc <= RESET_PC;
    else if (load) pc <= next_pc;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single outstanding fetch, hands inst/pc to decode,
// applies redirects at retire and stops on ECALL or a misaligned target.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            pc_load;
  logic            retire;
  logic            mis_set;
  logic [XLEN-1:0] inst_q, inst_pc_q;
  logic [31:0]     retire_cnt;
  logic            mis_q;

  pc_register #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load),
    .next_pc (pc_nxt),
    .pc      (pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_nxt;
  end

  // Next state and next pc; halt beats a misaligned redirect beats a redirect.
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_nxt    = pc + PC_INC;
    retire    = 1'b0;
    mis_set   = 1'b0;
    case (state)
      S_REQ:  if (bus.imem_gnt)    state_nxt = S_WAIT;
      S_WAIT: if (bus.imem_rvalid) state_nxt = S_VALID;
      S_VALID: begin
        if (bus.inst_ready) begin
          retire = 1'b1;
          if (bus.halt_req) begin
            state_nxt = S_HALT;
          end else if (bus.redirect && (bus.redirect_target[1:0] != 2'b00)) begin
            state_nxt = S_HALT;
            mis_set   = 1'b1;
          end else if (bus.redirect) begin
            pc_load   = 1'b1;
            pc_nxt    = bus.redirect_target;
            state_nxt = S_REQ;
          end else begin
            pc_load   = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_REQ;
    endcase
  end

  // Capture fetched word with its pc, count retires, latch misaligned stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q     <= '0;
      inst_pc_q  <= '0;
      retire_cnt <= '0;
      mis_q      <= 1'b0;
    end else begin
      if (state == S_WAIT && bus.imem_rvalid) begin
        inst_q    <= bus.imem_rdata;
        inst_pc_q <= pc;
      end
      if (retire)  retire_cnt <= retire_cnt + 32'd1;
      if (mis_set) mis_q      <= 1'b1;
    end
  end

  // Strobes are forced low while reset is held.
  assign bus.imem_req     = (state == S_REQ)   && !reset;
  assign bus.imem_addr    = pc;
  assign bus.inst_valid   = (state == S_VALID) && !reset;
  assign bus.halted       = (state == S_HALT)  && !reset;
  assign bus.inst         = inst_q;
  assign bus.inst_pc      = inst_pc_q;
  assign bus.misaligned   = mis_q;
  assign bus.retire_count = retire_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench plays instruction memory and decode,
// scoreboard holds {pc, word} for each fetch and is checked at retire.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_retire = '0;
  logic [63:0] sb[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.imem_gnt        = 1'b0;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = '0;
    bus.inst_ready      = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.halt_req        = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_retire = '0;
    sb.delete();
  endtask

  // Play memory for one fetch at expected address a; called at a negedge in REQ.
  task automatic serve(input logic [31:0] a, input int gd, input int rd, input bit spur);
    chk("req_addr", bus.imem_addr, a);
    chk("req_high", {31'b0, bus.imem_req}, 32'd1);
    for (int i = 0; i < gd; i++) begin
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = spur && (i == 0);
      bus.imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      chk("addr_stable", bus.imem_addr, a);
      chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
    end
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    chk("req_low_wait", {31'b0, bus.imem_req}, 32'd0);
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      chk("req_low_wait", {31'b0, bus.imem_req}, 32'd0);
      chk("valid_low_wait", {31'b0, bus.inst_valid}, 32'd0);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word_at(a);
    sb.push_back({a, word_at(a)});
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    chk("inst_valid", {31'b0, bus.inst_valid}, 32'd1);
  endtask

  // Act as decode: hold off for `hold` cycles, then retire once.
  task automatic retire(input int hold, input bit redir, input logic [31:0] tgt, input bit hreq);
    logic [63:0] e;
    e = '0;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
    end
    chk("inst", bus.inst, e[31:0]);
    chk("inst_pc", bus.inst_pc, e[63:32]);
    for (int i = 0; i < hold; i++) begin
      bus.inst_ready = 1'b0;
      @(negedge clk);
      chk("bp_inst", bus.inst, e[31:0]);
      chk("bp_inst_pc", bus.inst_pc, e[63:32]);
      chk("bp_valid", {31'b0, bus.inst_valid}, 32'd1);
      chk("bp_no_req", {31'b0, bus.imem_req}, 32'd0);
      chk("bp_count", bus.retire_count, exp_retire);
    end
    bus.inst_ready      = 1'b1;
    bus.redirect        = redir;
    bus.redirect_target = tgt;
    bus.halt_req        = hreq;
    @(negedge clk);
    clear_inputs();
    exp_retire++;
    chk("retire_count", bus.retire_count, exp_retire);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst_halted", {31'b0, bus.halted}, 32'd0);
    chk("rst_mis", {31'b0, bus.misaligned}, 32'd0);
    chk("rst_count", bus.retire_count, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back sequential fetch, 3 cycles per instruction.
    serve(32'h0, 0, 0, 1'b0); retire(0, 1'b0, 32'h0, 1'b0);
    serve(32'h4, 0, 0, 1'b0); retire(0, 1'b0, 32'h0, 1'b0);
    serve(32'h8, 0, 0, 1'b0); retire(0, 1'b0, 32'h0, 1'b0);
    chk("seq_count3", bus.retire_count, 32'd3);
    chk("seq_next_addr", bus.imem_addr, 32'hC);

    // Backpressure for 5 cycles, then exactly one retire.
    serve(32'hC, 0, 0, 1'b0); retire(5, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("bp_single_retire", bus.retire_count, 32'd4);

    // Memory stall with spurious rvalid in REQ.
    serve(32'h10, 4, 3, 1'b1); retire(0, 1'b0, 32'h0, 1'b0);

    // Redirect aligned, then misaligned.
    serve(32'h14, 0, 0, 1'b0); retire(0, 1'b1, 32'h100, 1'b0);
    serve(32'h100, 1, 1, 1'b0); retire(0, 1'b1, 32'h102, 1'b0);
    chk("mis_halted", {31'b0, bus.halted}, 32'd1);
    chk("mis_flag", {31'b0, bus.misaligned}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mis_no_req", {31'b0, bus.imem_req}, 32'd0);
    end
    chk("mis_inst_pc_kept", bus.inst_pc, 32'h100);

    // Halt wins over a simultaneous redirect.
    do_reset();
    serve(32'h0, 0, 0, 1'b0); retire(0, 1'b1, 32'h200, 1'b1);
    chk("halt_halted", {31'b0, bus.halted}, 32'd1);
    chk("halt_mis", {31'b0, bus.misaligned}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_no_req", {31'b0, bus.imem_req}, 32'd0);
      chk("halt_no_valid", {31'b0, bus.inst_valid}, 32'd0);
    end
    chk("halt_inst_kept", bus.inst, word_at(32'h0));
    chk("halt_count", bus.retire_count, 32'd1);

    // Reset while waiting on rvalid.
    do_reset();
    serve(32'h0, 0, 0, 1'b0); retire(0, 1'b0, 32'h0, 1'b0);
    chk("mid_addr", bus.imem_addr, 32'h4);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    chk("mid_in_wait", {31'b0, bus.imem_req}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, bus.imem_req}, 32'd1);
    chk("mid_rst_addr", bus.imem_addr, 32'h0);
    chk("mid_rst_count", bus.retire_count, 32'd0);
    chk("mid_rst_halted", {31'b0, bus.halted}, 32'd0);
    chk("mid_rst_inst", bus.inst, 32'd0);
    exp_retire = '0;
    sb.delete();
    @(negedge clk);

    // PC wrap at the top of the address space.
    serve(32'h0, 0, 0, 1'b0); retire(0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    serve(32'hFFFF_FFFC, 0, 0, 1'b0); retire(0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    chk("wrap_req", {31'b0, bus.imem_req}, 32'd1);
    serve(32'h0, 0, 1, 1'b0); retire(1, 1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
